// File: rtl/lfsr_checker.sv
// PRBS receive-side checker: self-seeds from the incoming stream, then
// predicts each bit from its own register and tallies mismatches.
module lfsr_checker #(
  parameter int                 LFSR_SIZE = 7,
  parameter logic [LFSR_SIZE:0] LFSR_POLY = 8'b11000001,
  parameter int                 ERR_LIMIT = 4,
  parameter int                 CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 bit_err,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic [LFSR_SIZE-1:0] state_out
);

  localparam int FW = $clog2(LFSR_SIZE + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(LFSR_SIZE - 1);
  localparam logic [FW-1:0] FILL_ONE = FW'(1);
  localparam logic [7:0] LIM = 8'(ERR_LIMIT);
  localparam logic [LFSR_SIZE-1:0] TAPS = LFSR_POLY[LFSR_SIZE:1];
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {
    SEED,
    LOCK
  } fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic [LFSR_SIZE-1:0] state_q, state_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [7:0]           cons_q, cons_d;
  logic                 bit_err_q, bit_err_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [LFSR_SIZE-1:0] seed_nxt;
  logic                 fb;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= SEED;
      state_q   <= '0;
      fill_q    <= '0;
      cons_q    <= '0;
      bit_err_q <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      fill_q    <= fill_d;
      cons_q    <= cons_d;
      bit_err_q <= bit_err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    fill_d    = fill_q;
    cons_d    = cons_q;
    bit_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    fb        = ^(state_q & TAPS);
    seed_nxt  = {state_q[LFSR_SIZE-2:0], bit_in};
    if (bit_valid) begin
      unique case (fsm_q)
        SEED: begin
          state_d = seed_nxt;
          fill_d  = fill_q + FILL_ONE;
          if (fill_q == FILL_LAST) begin
            fill_d = '0;
            if (|seed_nxt) fsm_d = LOCK;
          end
        end
        LOCK: begin
          // Shift the prediction, not the received bit, so errors don't propagate
          state_d = {state_q[LFSR_SIZE-2:0], fb};
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_ONE;
          if (bit_in != fb) begin
            bit_err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
            cons_d = cons_q + 8'd1;
            if (cons_d == LIM) begin
              fsm_d  = SEED;
              fill_d = '0;
              cons_d = '0;
            end
          end else begin
            cons_d = '0;
          end
        end
      endcase
    end
    if (clear_cnt) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  assign locked    = (fsm_q == LOCK);
  assign bit_err   = bit_err_q;
  assign err_count = err_cnt_q;
  assign bit_count = bit_cnt_q;
  assign state_out = state_q;

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side counterpart of the team's Fibonacci LFSR generator. It consumes the serial bit stream the generator emits (one new feedback bit per enable step) and self-synchronises by seeding its own register from the first LFSR_SIZE received bits. It then predicts every following bit and reports mismatches and error statistics. It is used as a BIST/PRBS monitor on crypto-core LFSR paths.

Parameters:
LFSR_SIZE, 7, register width in bits (>=3)
LFSR_POLY, 8'b11000001, tap mask of width LFSR_SIZE+1; bits [LFSR_SIZE:1] select data bits, same encoding as the generator
ERR_LIMIT, 4, consecutive mismatches that drop lock (1..255)
CNT_WIDTH, 16, width of the bit and error counters

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
bit_valid  input  1  bit_in is sampled on this cycle
bit_in  input  1  received serial bit (the generator's new LSB)
clear_cnt  input  1  synchronous clear of bit_count and err_count
locked  output  1  checker synchronised and predicting
bit_err  output  1  one-cycle pulse: last checked bit mismatched
err_count  output  CNT_WIDTH  saturating count of mismatches while locked
bit_count  output  CNT_WIDTH  saturating count of bits checked while locked
state_out  output  LFSR_SIZE  current checker register

Behaviour:
- Reset (reset=1 at a clk edge) has priority over everything. All outputs and the internal fill counter go to 0, and the FSM enters SEED.
- Feedback function: fb = ^(state_out & LFSR_POLY[LFSR_SIZE:1]). Shift is state_out <= {state_out[LFSR_SIZE-2:0], x}.
- FSM states: SEED, LOCK. Cycles with bit_valid=0 change nothing except that bit_err is 0 and clear_cnt is honoured.
- SEED, on each valid bit:
  - shift in bit_in and increment the fill counter.
  - On the LFSR_SIZE-th bit, check the resulting register value. If it is nonzero, go to LOCK; locked rises on that same edge, visible the next cycle.
  - If the resulting register value is all zeros, that is an illegal LFSR state. Reset the fill counter to 0 and stay in SEED.
  - No counters update and bit_err stays 0 in SEED.
- LOCK, on each valid bit:
  - Compute exp = fb. Shift exp (not bit_in) into the register, so channel errors do not corrupt the prediction.
  - Increment bit_count (saturating at all-ones).
  - If bit_in != exp: bit_err=1 on the next cycle, increment err_count (saturating), and increment the consecutive-error counter (8 bits).
  - If bit_in == exp: clear the consecutive-error counter.
  - When a mismatch makes the consecutive count equal ERR_LIMIT: go to SEED on the same edge, clear the fill counter and the consecutive counter, and drop locked. The register is re-seeded from subsequent bits. bit_err and err_count still report that mismatch.
- bit_err is registered: high exactly one cycle, the cycle after the offending valid sample.
- clear_cnt zeroes bit_count and err_count on the edge. If a valid bit arrives in the same cycle, clear wins and that bit is not counted. Lock state and bit_err are unaffected.
- Counters hold their values across loss of lock. Only reset or clear_cnt zeroes them.
- Latency: sample at edge N means locked, bit_err and counters reflect it after edge N.

Test Plan:
- Seed/lock: reset, then feed the default generator stream from init 7'b1111010. Bits are 0,0,0,1,... (states 1110100, 1101000, 1010000, 0100001, ...). After the 7th valid bit: locked=1, state_out equals the generator's data_out, bit_count=0.
- Clean run: drive 1000 further correct bits with random bit_valid gaps. Expect bit_count=1000, err_count=0, bit_err never high, state_out tracking the generator every step.
- Single error: flip one bit while locked. Expect a single bit_err pulse, err_count=1, locked stays 1, and the next 20 correct bits produce no bit_err (prediction not corrupted).
- Lock loss: inject 4 consecutive flipped bits. Expect 4 bit_err pulses, err_count=4, locked=0 after the 4th. Then 7 correct bits relock with no further errors counted.
- Zero seed: after reset, send 7 zeros. Expect locked=0 and fill restarted. Then 7 valid stream bits give locked=1.
- Priority/saturation: clear_cnt together with a mismatching valid bit gives err_count=0 and bit_err=1. With CNT_WIDTH=4, 20 errors non-consecutive (ERR_LIMIT=255) leave err_count=15. Reset mid-LOCK gives all outputs 0 and the FSM back in SEED.
